// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read, an instruction
// register handed to decode, redirect squashing and a sticky bus-timeout trap.
module fetch_ctrl #(
    parameter logic [31:0] INITAL_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] pc_addr,
    input  logic        redirect,
    output logic        pc_step,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DROP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;
    logic [31:0] imem_addr_r;
    logic [31:0] imem_addr_nxt_s;
    logic [31:0] ir_r;
    logic [31:0] ir_nxt_s;
    logic        ir_valid_r;
    logic        ir_valid_nxt_s;
    logic        imem_req_r;
    logic        imem_req_nxt_s;
    logic        pc_step_r;
    logic        pc_step_nxt_s;
    logic        fetch_err_r;
    logic        fetch_err_nxt_s;
    logic        timeout_s;

    assign timeout_s = (wait_cnt_r == WAIT_LAST) ? 1'b1 : 1'b0;

    // State, counter and output registers; rest overrides everything.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 8'd0;
            imem_addr_r <= INITAL_ADDR;
            ir_r        <= 32'h0000_0000;
            ir_valid_r  <= 1'b0;
            imem_req_r  <= 1'b0;
            pc_step_r   <= 1'b0;
            fetch_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            imem_addr_r <= imem_addr_nxt_s;
            ir_r        <= ir_nxt_s;
            ir_valid_r  <= ir_valid_nxt_s;
            imem_req_r  <= imem_req_nxt_s;
            pc_step_r   <= pc_step_nxt_s;
            fetch_err_r <= fetch_err_nxt_s;
        end
    end

    // Next-state decision; an ack always wins over the timeout in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERR;
                end else if (redirect) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect || ir_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the chosen transition.
    always_comb begin
        imem_addr_nxt_s = imem_addr_r;
        ir_nxt_s        = ir_r;
        wait_cnt_nxt_s  = 8'd0;
        imem_req_nxt_s  = ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DROP)) ? 1'b1 : 1'b0;
        ir_valid_nxt_s  = (state_nxt_s == ST_HOLD) ? 1'b1 : 1'b0;
        fetch_err_nxt_s = (state_nxt_s == ST_ERR) ? 1'b1 : 1'b0;
        pc_step_nxt_s   = ((state_r == ST_FETCH) && (state_nxt_s == ST_HOLD)) ? 1'b1 : 1'b0;
        if (state_r == ST_IDLE) begin
            imem_addr_nxt_s = pc_addr;
        end else begin
            imem_addr_nxt_s = imem_addr_r;
        end
        if (pc_step_nxt_s) begin
            ir_nxt_s = imem_data;
        end else begin
            ir_nxt_s = ir_r;
        end
        // Counting only continues while staying in the same waiting state.
        if (imem_req_nxt_s && (state_nxt_s == state_r)) begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_nxt_s = 8'd0;
        end
    end

    assign pc_step   = pc_step_r;
    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign ir        = ir_r;
    assign ir_valid  = ir_valid_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a flag-based reference model compared every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fetch_ctrl;

    localparam logic [31:0] INIT_A = 32'hBFC0_0000;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rest, redirect, imem_ack, ir_ready;
    logic [31:0] pc_addr, imem_data;
    logic        pc_step, imem_req, ir_valid, fetch_err;
    logic [31:0] imem_addr, ir;

    int n_checks = 0;
    int n_fail   = 0;
    int step_cnt = 0;
    bit chk_en   = 1'b0;

    // Reference model: the outputs themselves tell which phase we are in.
    logic        m_req, m_valid, m_step, m_err, m_discard;
    logic [31:0] m_addr, m_ir;
    int          m_waits;

    fetch_ctrl #(.INITAL_ADDR(INIT_A), .TIMEOUT(TMO)) dut (
        .clk(clk), .rest(rest), .pc_addr(pc_addr), .redirect(redirect),
        .pc_step(pc_step), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rest) begin
            m_req = 1'b0; m_valid = 1'b0; m_step = 1'b0; m_err = 1'b0;
            m_discard = 1'b0; m_addr = INIT_A; m_ir = 32'h0; m_waits = 0;
        end else if (!m_err) begin
            m_step = 1'b0;
            if (m_req) begin
                if (imem_ack) begin
                    m_req = 1'b0;
                    if (!m_discard && !redirect) begin
                        m_ir = imem_data; m_valid = 1'b1; m_step = 1'b1;
                    end
                    m_discard = 1'b0;
                    m_waits = 0;
                end else if (m_waits == TMO - 1) begin
                    m_req = 1'b0; m_err = 1'b1; m_discard = 1'b0; m_waits = 0;
                end else if (redirect && !m_discard) begin
                    m_discard = 1'b1; m_waits = 0;
                end else begin
                    m_waits++;
                end
            end else if (m_valid) begin
                if (redirect || ir_ready) m_valid = 1'b0;
            end else begin
                m_addr = pc_addr;
                if (!redirect) begin
                    m_req = 1'b1; m_waits = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (pc_step) step_cnt++;
        if (chk_en) begin
            check("cyc_imem_req",  {31'h0, imem_req},  {31'h0, m_req});
            check("cyc_imem_addr", imem_addr, m_addr);
            check("cyc_ir",        ir, m_ir);
            check("cyc_ir_valid",  {31'h0, ir_valid},  {31'h0, m_valid});
            check("cyc_pc_step",   {31'h0, pc_step},   {31'h0, m_step});
            check("cyc_fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
        end
    end

    task automatic cyc(input logic rd, input logic ak, input logic [31:0] dt, input logic rdy);
        redirect = rd; imem_ack = ak; imem_data = dt; ir_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int s0;
        rest = 1'b1; redirect = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
        pc_addr = 32'h0000_0100; imem_data = 32'h0;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_addr",  imem_addr, INIT_A);
        check("rst_req",   {31'h0, imem_req}, 32'h0);
        check("rst_ir",    ir, 32'h0);

        // Basic fetch from 0x100, ack one cycle after the request.
        rest = 1'b0;
        s0 = step_cnt;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("f1_req",  {31'h0, imem_req}, 32'h1);
        check("f1_addr", imem_addr, 32'h0000_0100);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h2402_0005, 1'b1);
        check("f1_ir",    ir, 32'h2402_0005);
        check("f1_valid", {31'h0, ir_valid}, 32'h1);
        check("f1_step",  {31'h0, pc_step}, 32'h1);
        pc_addr = 32'h0000_0104;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("f1_step_once", {31'h0, pc_step}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("f1_step_count", step_cnt - s0, 32'd1);
        check("f2_addr", imem_addr, 32'h0000_0104);

        // Decode stalls five cycles in HOLD.
        s0 = step_cnt;
        cyc(1'b0, 1'b1, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            check("stall_valid", {31'h0, ir_valid}, 32'h1);
            check("stall_req",   {31'h0, imem_req}, 32'h0);
        end
        pc_addr = 32'h0000_0108;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("stall_step_count", step_cnt - s0, 32'd1);

        // Redirect in FETCH, ack two cycles later is discarded.
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("d_addr", imem_addr, 32'h0000_0108);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        pc_addr = 32'h0000_0400;
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("d_ir_kept", ir, 32'h1111_1111);
        check("d_no_step", {31'h0, pc_step}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("d_next_addr", imem_addr, 32'h0000_0400);

        // Redirect with ack, then redirect with ready in HOLD.
        cyc(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
        check("ra_valid", {31'h0, ir_valid}, 32'h0);
        pc_addr = 32'h0000_0500;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("ra_addr", imem_addr, 32'h0000_0500);
        cyc(1'b0, 1'b1, 32'h3C01_0001, 1'b0);
        pc_addr = 32'h0000_0600;
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("rh_valid", {31'h0, ir_valid}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("rh_addr", imem_addr, 32'h0000_0600);

        // Ack during HOLD ignored, redirect in IDLE holds IDLE a cycle.
        cyc(1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
        cyc(1'b0, 1'b1, 32'h9999_9999, 1'b1);
        check("hold_ack_ign", ir, 32'h5555_AAAA);
        pc_addr = 32'h0000_0700;
        cyc(1'b1, 1'b1, 32'h7777_7777, 1'b0);
        check("idle_redir_req", {31'h0, imem_req}, 32'h0);
        pc_addr = 32'h0000_0800;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("idle_redir_addr", imem_addr, 32'h0000_0800);

        // Bus timeout: 16 request cycles, then sticky error.
        for (int i = 0; i < TMO; i++) begin
            check("tmo_req_high", {31'h0, imem_req}, 32'h1);
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
        end
        check("tmo_req_low", {31'h0, imem_req}, 32'h0);
        check("tmo_err",     {31'h0, fetch_err}, 32'h1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'hBAD0_0001, 1'b1);
        check("tmo_err_held", {31'h0, fetch_err}, 32'h1);
        check("tmo_late_ack", ir, 32'h5555_AAAA);
        rest = 1'b1; pc_addr = 32'h0000_0900;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("tmo_rst_err",  {31'h0, fetch_err}, 32'h0);
        check("tmo_rst_addr", imem_addr, INIT_A);
        rest = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("tmo_restart", imem_addr, 32'h0000_0900);

        // Reset mid-FETCH with ack in the same cycle.
        rest = 1'b1;
        cyc(1'b0, 1'b1, 32'h1234_5678, 1'b1);
        check("mr_ir",    ir, 32'h0);
        check("mr_valid", {31'h0, ir_valid}, 32'h0);
        check("mr_step",  {31'h0, pc_step}, 32'h0);
        check("mr_req",   {31'h0, imem_req}, 32'h0);
        rest = 1'b0;
        cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        check("mr_ack_ign", ir, 32'h0);
        cyc(1'b0, 1'b1, 32'h0000_000C, 1'b1);
        check("mr_refetch", ir, 32'h0000_000C);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter INITAL_ADDR, default 32'h0000_0000, fetch address held in imem_addr after reset.
REQ-002 Parameter TIMEOUT, default 16, max cycles a request may wait for imem_ack; legal range 2..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rest  in  1  synchronous, active-high reset.
REQ-005 pc_addr  in  32  current program-counter value.
REQ-006 redirect  in  1  one-cycle pulse: PC was loaded with a branch/jump/JR/COP0 target this cycle.
REQ-007 pc_step  out  1  registered one-cycle pulse permitting the PC to advance sequentially.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  32  instruction-memory read address.
REQ-010 imem_ack  in  1  memory response; imem_data valid in the same cycle.
REQ-011 imem_data  in  32  instruction word from memory.
REQ-012 ir  out  32  fetched instruction register.
REQ-013 ir_valid  out  1  ir holds an instruction for decode.
REQ-014 ir_ready  in  1  decode consumes ir this cycle when ir_valid=1.
REQ-015 fetch_err  out  1  sticky bus-timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, DROP, ERR; all outputs registered.
REQ-017 IDLE: latch imem_addr <= pc_addr; next state FETCH; stay IDLE one further cycle if redirect=1.
REQ-018 FETCH: imem_req=1, imem_addr stable; on imem_ack: ir <= imem_data, ir_valid <= 1, pc_step pulses 1 for the next cycle only, next state HOLD.
REQ-019 HOLD: ir and ir_valid held; on ir_ready: ir_valid <= 0, next state IDLE (PC has updated from pc_step by the time IDLE samples pc_addr).
REQ-020 Redirect in FETCH without imem_ack: next state DROP; imem_req stays 1 and imem_addr stays unchanged until ack.
REQ-021 Redirect in FETCH with imem_ack in the same cycle: data discarded, ir/ir_valid unchanged (0), no pc_step, next state IDLE.
REQ-022 Redirect in HOLD: ir_valid <= 0, no consumption required, next state IDLE; redirect takes priority over ir_ready.
REQ-023 DROP: imem_req=1; on imem_ack: data discarded, no pc_step, next state IDLE; further redirects ignored.
REQ-024 Wait counter (8 bits): cleared on entry to FETCH/DROP and on ack; increments each FETCH/DROP cycle without ack.
REQ-025 Counter == TIMEOUT-1 with no ack: next state ERR; imem_req <= 0, fetch_err <= 1.
REQ-026 ERR: absorbing until rest; imem_req=0, ir_valid=0, pc_step=0; redirect, ir_ready, imem_ack ignored.
REQ-027 imem_ack outside FETCH/DROP SHALL be ignored.
REQ-028 pc_step SHALL pulse at most once per accepted instruction, never two consecutive cycles.
REQ-029 Nominal latency: IDLE->FETCH 1 cycle; ack -> ir_valid next cycle; minimum 3 cycles per instruction (IDLE, FETCH with ack, HOLD with ready).

Reset
REQ-030 rest=1 at a posedge SHALL force: state IDLE, imem_addr=INITAL_ADDR, imem_req=0, ir=0, ir_valid=0, pc_step=0, fetch_err=0, counter=0.
REQ-031 rest SHALL override every other input in the same cycle, including from ERR and mid-request; an outstanding memory ack after reset is ignored unless the FSM is in FETCH again.

Verification
REQ-032 Reset, pc_addr=0x100, imem_ack 1 cycle after req with 0x2402_0005, ir_ready=1 -> imem_addr=0x100, ir=0x2402_0005, ir_valid 1, single pc_step pulse.
REQ-033 ir_ready low 5 cycles in HOLD -> ir_valid and ir stable 5 cycles, no new imem_req, pc_step pulsed once only.
REQ-034 redirect in FETCH, ack 2 cycles later with 0xDEAD_BEEF, pc_addr=0x400 -> data not in ir, no pc_step, next request imem_addr=0x400.
REQ-035 redirect and imem_ack same cycle; then redirect and ir_ready same cycle in HOLD -> ir_valid stays/falls 0, next fetch from new pc_addr.
REQ-036 No imem_ack for TIMEOUT=16 cycles -> imem_req drops after 16 request cycles, fetch_err=1 held; late ack ignored; rest clears fetch_err and restarts at INITAL_ADDR.
REQ-037 rest asserted mid-FETCH with ack same cycle -> all outputs at reset values next cycle, ir=0.
